egg_countdown: RTL and testbench

Consumer end of the timer's clock-divider outputs. Takes the free-running 1 Hz and 500 Hz square waves and converts each into a single-cycle strobe in the CLK100Mhz domain. Runs an mm:ss BCD countdown under start/stop/load control and drives the alarm output when the count expires. It sits between the clock divider and the BCD display/buzzer logic.

---
 rtl/egg_timer_pkg.sv | 36 +++
 rtl/pulse_sync.sv | 33 +++
 rtl/egg_countdown.sv | 157 +++++++++++++++
 tb/tb_egg_countdown.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// rtl/egg_timer_pkg.sv - shared state encoding, BCD constants and load clamps for the egg timer
// Purpose: common types and helpers imported by egg_countdown.
// Contents: state_t (IDLE/RUN/PAUSE/DONE), BCD digit limits, ALARM_SEC default,
//           clamp helpers that saturate out-of-range BCD nibbles on load.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX      = 4'd5;
  localparam logic [3:0] DIGIT_MAX         = 4'd9;
  localparam logic [7:0] SEC_RELOAD        = 8'h59;
  localparam int         ALARM_SEC_DEFAULT = 10;

  // Saturate each nibble to its legal BCD maximum.
  function automatic logic [7:0] clamp_sec(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (v[7:4] > SEC_TENS_MAX) ? SEC_TENS_MAX : v[7:4];
    units = (v[3:0] > DIGIT_MAX) ? DIGIT_MAX : v[3:0];
    return {tens, units};
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (v[7:4] > DIGIT_MAX) ? DIGIT_MAX : v[7:4];
    units = (v[3:0] > DIGIT_MAX) ? DIGIT_MAX : v[3:0];
    return {tens, units};
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - synchronizer plus rising-edge detector for an asynchronous square wave
// Purpose: bring an asynchronous square wave into the CLK100Mhz domain and emit
//          one registered single-cycle strobe per rising edge.
// Ports:
//   CLK100Mhz  in   system clock
//   reset_n    in   asynchronous active-low reset
//   async_in   in   asynchronous square wave
//   strobe     out  one-cycle pulse, SYNC_STAGES+1 cycles after the input edge
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK100Mhz,
  input  logic reset_n,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge CLK100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], async_in};
      prev   <= sync[SYNC_STAGES-1];
      strobe <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/egg_countdown.sv
// rtl/egg_countdown.sv - mm:ss BCD countdown with start/stop/load control and alarm
// Purpose: converts the divider's 1 Hz / 500 Hz square waves into strobes, runs
//          the countdown FSM and drives the alarm tone in DONE.
// Optional feature: EGG_ALARM_TIMEOUT_EN - DONE returns to IDLE after ALARM_SEC seconds.
// Ports:
//   CLK100Mhz, reset_n     clock and asynchronous active-low reset
//   pulse_1Hz, pulse_500Hz asynchronous square waves from the divider
//   start, stop, load      single-cycle control strobes (synchronous)
//   load_min, load_sec     BCD time captured on load (clamped)
//   min_bcd, sec_bcd       current count, BCD
//   running, done          state flags for RUN / DONE
//   alarm                  500 Hz tone while in DONE
//   tick_500               one-cycle strobe per 500 Hz rising edge
module egg_countdown
  import egg_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ALARM_SEC   = ALARM_SEC_DEFAULT
) (
  input  logic       CLK100Mhz,
  input  logic       reset_n,
  input  logic       pulse_1Hz,
  input  logic       pulse_500Hz,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       tick_500
);

  if (SYNC_STAGES < 2 || ALARM_SEC < 1) begin : g_param_check
    $error("egg_countdown: SYNC_STAGES must be >= 2 and ALARM_SEC >= 1");
  end

  state_t state;
  logic   tick_1s;

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
    .CLK100Mhz (CLK100Mhz),
    .reset_n   (reset_n),
    .async_in  (pulse_1Hz),
    .strobe    (tick_1s)
  );

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_500hz (
    .CLK100Mhz (CLK100Mhz),
    .reset_n   (reset_n),
    .async_in  (pulse_500Hz),
    .strobe    (tick_500)
  );

  // The alarm needs the 500 Hz level, not its strobe, so keep a separate level chain.
  logic [SYNC_STAGES-1:0] level_500;

  always_ff @(posedge CLK100Mhz or negedge reset_n) begin
    if (!reset_n) level_500 <= '0;
    else          level_500 <= {level_500[SYNC_STAGES-2:0], pulse_500Hz};
  end

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, DIGIT_MAX};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Next count for a 1 s tick; an already-zero count stays zero (and is caught as expiry).
  logic [7:0] dec_min;
  logic [7:0] dec_sec;
  logic       dec_zero;
  logic       time_nonzero;

  always_comb begin
    dec_min = min_bcd;
    dec_sec = sec_bcd;
    if (sec_bcd != 8'h00) begin
      dec_sec = bcd_dec(sec_bcd);
    end else if (min_bcd != 8'h00) begin
      dec_min = bcd_dec(min_bcd);
      dec_sec = SEC_RELOAD;
    end
  end

  assign dec_zero     = (dec_min == 8'h00) && (dec_sec == 8'h00);
  assign time_nonzero = (min_bcd != 8'h00) || (sec_bcd != 8'h00);

`ifdef EGG_ALARM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ALARM_SEC + 1);
  logic [CNT_W-1:0] alarm_cnt;
`endif

  always_ff @(posedge CLK100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
`ifdef EGG_ALARM_TIMEOUT_EN
      alarm_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!stop) begin
            if (start) begin
              if (time_nonzero) state <= RUN;
            end else if (load) begin
              min_bcd <= clamp_min(load_min);
              sec_bcd <= clamp_sec(load_sec);
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
          end else if (tick_1s) begin
            min_bcd <= dec_min;
            sec_bcd <= dec_sec;
            if (dec_zero) state <= DONE;
`ifdef EGG_ALARM_TIMEOUT_EN
            alarm_cnt <= '0;
`endif
          end
        end
        PAUSE: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state <= RUN;
          end else if (load) begin
            min_bcd <= clamp_min(load_min);
            sec_bcd <= clamp_sec(load_sec);
          end
        end
        DONE: begin
          if (stop || start) begin
            state <= IDLE;
`ifdef EGG_ALARM_TIMEOUT_EN
          end else if (tick_1s) begin
            if (alarm_cnt == CNT_W'(ALARM_SEC - 1)) state <= IDLE;
            else                                    alarm_cnt <= alarm_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign alarm   = (state == DONE) && level_500[SYNC_STAGES-1];

endmodule

// File: tb/tb_egg_countdown.sv
// tb/tb_egg_countdown.sv - self-checking directed bench for egg_countdown
module tb_egg_countdown;
  import egg_timer_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_1Hz = 1'b0;
  logic       pulse_500Hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;
  logic       tick_500;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  egg_countdown #(.SYNC_STAGES(2), .ALARM_SEC(3)) dut (
    .CLK100Mhz   (clk),
    .reset_n     (reset_n),
    .pulse_1Hz   (pulse_1Hz),
    .pulse_500Hz (pulse_500Hz),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .load_min    (load_min),
    .load_sec    (load_sec),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd),
    .running     (running),
    .done        (done),
    .alarm       (alarm),
    .tick_500    (tick_500)
  );

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    load_min = m; load_sec = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // One full 1 Hz period, compressed; strobe and count update settle well inside it.
  task automatic one_tick();
    @(negedge clk); pulse_1Hz = 1'b1;
    repeat (6) @(negedge clk);
    pulse_1Hz = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (min_bcd !== 8'h00) begin errors++; $display("FAIL reset_min: got %h want 00", min_bcd); end
    checks++; if (sec_bcd !== 8'h00) begin errors++; $display("FAIL reset_sec: got %h want 00", sec_bcd); end
    checks++; if ({running, done, alarm, tick_500} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {running, done, alarm, tick_500}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_countdown();
    int n500;
    do_load(8'h00, 8'h03);
    checks++; if (sec_bcd !== 8'h03) begin errors++; $display("FAIL cd_load: got %h want 03", sec_bcd); end
    do_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_running: got %b want 1", running); end
    one_tick();
    checks++; if (sec_bcd !== 8'h02) begin errors++; $display("FAIL cd_02: got %h want 02", sec_bcd); end
    one_tick();
    checks++; if (sec_bcd !== 8'h01) begin errors++; $display("FAIL cd_01: got %h want 01", sec_bcd); end
    one_tick();
    checks++; if ({min_bcd, sec_bcd} !== 16'h0000) begin errors++; $display("FAIL cd_00: got %h want 0000", {min_bcd, sec_bcd}); end
    checks++; if ({running, done} !== 2'b01) begin errors++; $display("FAIL cd_done: got %b want 01", {running, done}); end
    n500 = 0;
    pulse_500Hz = 1'b1;
    repeat (8) begin @(negedge clk); n500 += int'(tick_500); end
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_high: got %b want 1", alarm); end
    pulse_500Hz = 1'b0;
    repeat (8) begin @(negedge clk); n500 += int'(tick_500); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_low: got %b want 0", alarm); end
    checks++; if (n500 != 1) begin errors++; $display("FAIL tick_500_count: got %0d want 1", n500); end
`ifdef EGG_ALARM_TIMEOUT_EN
    pulse_500Hz = 1'b1;
    one_tick(); one_tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", done); end
    one_tick();
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL timeout_idle: got %0d want 0", dut.state); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL timeout_alarm: got %b want 0", alarm); end
    pulse_500Hz = 1'b0;
`else
    repeat (20) one_tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_persist: got %b want 1", done); end
    checks++; if ({min_bcd, sec_bcd} !== 16'h0000) begin errors++; $display("FAIL done_hold: got %h want 0000", {min_bcd, sec_bcd}); end
    do_stop();
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL done_ack: got %0d want 0", dut.state); end
`endif
    repeat (10) @(negedge clk);
  endtask

  task automatic test_borrow();
    do_load(8'h01, 8'h00);
    do_start();
    one_tick();
    checks++; if ({min_bcd, sec_bcd} !== 16'h0059) begin errors++; $display("FAIL borrow_0100: got %h want 0059", {min_bcd, sec_bcd}); end
    do_stop(); do_stop();
    do_load(8'h10, 8'h00);
    do_start();
    one_tick();
    checks++; if ({min_bcd, sec_bcd} !== 16'h0959) begin errors++; $display("FAIL borrow_1000: got %h want 0959", {min_bcd, sec_bcd}); end
    do_stop(); do_stop();
  endtask

  task automatic test_clamp();
    do_load(8'hAF, 8'h7C);
    checks++; if ({min_bcd, sec_bcd} !== 16'h9959) begin errors++; $display("FAIL clamp: got %h want 9959", {min_bcd, sec_bcd}); end
    do_load(8'h00, 8'h00);
    do_start();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_start: got %b want 0", running); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL zero_state: got %0d want 0", dut.state); end
  endtask

  task automatic test_pause();
    do_load(8'h00, 8'h05);
    do_start();
    do_stop();
    checks++; if (dut.state !== PAUSE) begin errors++; $display("FAIL pause_state: got %0d want 2", dut.state); end
    one_tick();
    checks++; if (sec_bcd !== 8'h05) begin errors++; $display("FAIL pause_hold: got %h want 05", sec_bcd); end
    do_start();
    one_tick();
    checks++; if (sec_bcd !== 8'h04) begin errors++; $display("FAIL resume_04: got %h want 04", sec_bcd); end
    one_tick();
    checks++; if (sec_bcd !== 8'h03) begin errors++; $display("FAIL resume_03: got %h want 03", sec_bcd); end
    do_stop(); do_stop();
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL stop2_idle: got %0d want 0", dut.state); end
    checks++; if (sec_bcd !== 8'h03) begin errors++; $display("FAIL stop2_hold: got %h want 03", sec_bcd); end
  endtask

  task automatic test_collision();
    bit seen;
    do_load(8'h00, 8'h10);
    do_start();
    @(negedge clk); pulse_1Hz = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dut.tick_1s) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL coll_tick_seen: got 0 want 1"); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++; if (dut.state !== PAUSE) begin errors++; $display("FAIL coll_state: got %0d want 2", dut.state); end
    checks++; if ({min_bcd, sec_bcd} !== 16'h0010) begin errors++; $display("FAIL coll_count: got %h want 0010", {min_bcd, sec_bcd}); end
    pulse_1Hz = 1'b0;
    repeat (6) @(negedge clk);
    do_stop();
  endtask

  task automatic test_reset_mid();
    do_load(8'h00, 8'h05);
    do_start();
    one_tick();
    checks++; if (sec_bcd !== 8'h04) begin errors++; $display("FAIL mid_pre: got %h want 04", sec_bcd); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({min_bcd, sec_bcd, running, done, alarm, tick_500} !== 20'h0) begin
      errors++; $display("FAIL mid_reset: got %h want 00000", {min_bcd, sec_bcd, running, done, alarm, tick_500}); end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_clamp();
    test_pause();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
